vector_reg_file_v2: RTL and testbench

//  Parametrised LANES x DATA_WIDTH vector register file: 2 registered read ports, 1 write port with per-lane mask.

---
 rtl/vector_reg_file_v2_if.sv | 42 ++++
 rtl/vector_reg_file_v2.sv | 146 ++++++++++++++
 tb/tb_vector_reg_file_v2.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vector_reg_file_v2_if.sv
// Request/response bundle between issue logic and the vector register file.
interface vector_reg_file_v2_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned REG_COUNT  = 16
);
  localparam int unsigned AW = $clog2(REG_COUNT);
  localparam int unsigned VW = LANES * DATA_WIDTH;

  logic          we;
  logic [AW-1:0] w_addr;
  logic [LANES-1:0] w_lane_mask;
  logic [VW-1:0] w_data;
  logic          re1;
  logic          re2;
  logic [AW-1:0] r_addr1;
  logic [AW-1:0] r_addr2;
  logic [VW-1:0] r_data1;
  logic [VW-1:0] r_data2;
  logic          r_valid1;
  logic          r_valid2;
  logic          busy1;
  logic          busy2;
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic [3:0]    buttons;
  logic [7:0]    i_time;
  logic [7:0]    i_y;
  logic          init_done;

  modport master (
    output we, w_addr, w_lane_mask, w_data, re1, re2, r_addr1, r_addr2,
           issue_valid, issue_addr, buttons, i_time, i_y,
    input  r_data1, r_data2, r_valid1, r_valid2, busy1, busy2, init_done
  );

  modport slave (
    input  we, w_addr, w_lane_mask, w_data, re1, re2, r_addr1, r_addr2,
           issue_valid, issue_addr, buttons, i_time, i_y,
    output r_data1, r_data2, r_valid1, r_valid2, busy1, busy2, init_done
  );
endinterface

// File: rtl/vector_reg_file_v2.sv
// LANES x DATA_WIDTH vector register file: 2 registered read ports, masked write port,
// write->read bypass, pending-write scoreboard and a sequential post-reset clear.
module vector_reg_file_v2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned REG_COUNT  = 16
) (
  input logic clk,
  input logic rst,
  vector_reg_file_v2_if.slave bus
);
  localparam int unsigned AW = $clog2(REG_COUNT);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned VW = LANES * DATA_WIDTH;
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned S  = REG_COUNT - 4;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             init_done_q;
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [VW-1:0]    r_data1_q, r_data2_q;
  logic             r_valid1_q, r_valid2_q;
  logic [VW-1:0]    mem [1:S-1];

  logic             run;
  logic             wr_ok;
  logic             iss_ok;
  logic [AW-1:0]    w_addr;
  logic [LANES-1:0] w_mask;
  logic [VW-1:0]    w_data;
  logic [VW-1:0]    sp_buttons, sp_y, sp_lane, sp_time;

  function automatic logic is_storage(input logic [AW-1:0] a);
    return (a != '0) && (a < AW'(S));
  endfunction

  assign w_addr = bus.w_addr;
  assign w_mask = bus.w_lane_mask;
  assign w_data = bus.w_data;
  assign run    = (state_q == ST_RUN);
  assign wr_ok  = run && bus.we && is_storage(w_addr);
  assign iss_ok = run && bus.issue_valid && is_storage(bus.issue_addr);

  // Special read-only registers, replicated per lane
  always_comb begin
    sp_buttons = '0;
    sp_y       = '0;
    sp_lane    = '0;
    sp_time    = '0;
    for (int k = 0; k < LANES; k++) begin
      sp_buttons[k*DW +: DW] = DW'(bus.buttons);
      sp_y[k*DW +: DW]       = DW'(bus.i_y);
      sp_lane[k*DW +: DW]    = DW'(k) << (DW - LW);
      sp_time[k*DW +: DW]    = DW'(bus.i_time);
    end
  end

  // Storage reads see a same-cycle write merged lane by lane
  function automatic logic [VW-1:0] lookup(input logic [AW-1:0] a);
    logic [VW-1:0] v;
    v = '0;
    if (a == AW'(S))          v = sp_buttons;
    else if (a == AW'(S + 1)) v = sp_y;
    else if (a == AW'(S + 2)) v = sp_lane;
    else if (a == AW'(S + 3)) v = sp_time;
    else if (is_storage(a)) begin
      v = mem[a];
      if (wr_ok && (w_addr == a)) begin
        for (int k = 0; k < LANES; k++)
          if (w_mask[k]) v[k*DW +: DW] = w_data[k*DW +: DW];
      end
    end
    return v;
  endfunction

  // Clear sequencer: walk storage once after reset, then run forever
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_INIT) begin
      if (idx_q == AW'(S - 1)) state_d = ST_RUN;
      else                     idx_d   = idx_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      idx_q       <= AW'(1);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= (state_d == ST_RUN);
    end
  end

  // Storage array has no reset; the sequencer zeroes it instead
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem[idx_q] <= '0;
      end else if (wr_ok) begin
        for (int k = 0; k < LANES; k++)
          if (w_mask[k]) mem[w_addr][k*DW +: DW] <= w_data[k*DW +: DW];
      end
    end
  end

  // Scoreboard: issue sets, write clears, set wins on collision
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[w_addr]         = 1'b0;
    if (iss_ok) busy_d[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data1_q  <= '0;
      r_data2_q  <= '0;
      r_valid1_q <= 1'b0;
      r_valid2_q <= 1'b0;
    end else begin
      r_valid1_q <= run && bus.re1;
      r_valid2_q <= run && bus.re2;
      if (run && bus.re1) r_data1_q <= lookup(bus.r_addr1);
      if (run && bus.re2) r_data2_q <= lookup(bus.r_addr2);
    end
  end

  assign bus.r_data1   = r_data1_q;
  assign bus.r_data2   = r_data2_q;
  assign bus.r_valid1  = r_valid1_q;
  assign bus.r_valid2  = r_valid2_q;
  assign bus.init_done = init_done_q;
  assign bus.busy1     = busy_q[bus.r_addr1] & init_done_q;
  assign bus.busy2     = busy_q[bus.r_addr2] & init_done_q;
endmodule

// File: tb/tb_vector_reg_file_v2.sv
// Directed vector bench for vector_reg_file_v2 (DW=8, LANES=4, REG_COUNT=16).
module tb_vector_reg_file_v2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_reg_file_v2_if bus ();
  vector_reg_file_v2 dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        we;  logic [3:0] wa; logic [3:0] wm; logic [31:0] wd;
    logic        re1; logic [3:0] a1; logic re2; logic [3:0] a2;
    logic        iv;  logic [3:0] ia; logic [3:0] btn;
    logic        ev1; logic [31:0] ed1; logic ev2; logic [31:0] ed2;
    logic        eb1; logic eb2;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.we = 0; bus.w_addr = 0; bus.w_lane_mask = 0; bus.w_data = 0;
    bus.re1 = 0; bus.r_addr1 = 0; bus.re2 = 0; bus.r_addr2 = 0;
    bus.issue_valid = 0; bus.issue_addr = 0; bus.buttons = 0;
  endtask

  task automatic apply(input vec_t v);
    bus.we = v.we; bus.w_addr = v.wa; bus.w_lane_mask = v.wm; bus.w_data = v.wd;
    bus.re1 = v.re1; bus.r_addr1 = v.a1; bus.re2 = v.re2; bus.r_addr2 = v.a2;
    bus.issue_valid = v.iv; bus.issue_addr = v.ia; bus.buttons = v.btn;
  endtask

  task automatic wait_init(input string name);
    int cyc;
    cyc = 0;
    while (bus.init_done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 32'(cyc), 32'd11);
  endtask

  initial begin
    //           we wa  wm    wd             re1 a1 re2 a2  iv ia  btn   ev1 ed1           ev2 ed2           eb1 eb2
    tbl[0]  = '{0, 0, 4'h0, 32'h0,         1, 5,  1, 5,   0, 0,  4'h0, 1, 32'h00000000, 1, 32'h00000000, 0, 0};
    tbl[1]  = '{1, 3, 4'hF, 32'h11223344,  0, 3,  0, 3,   0, 0,  4'h0, 0, 32'h00000000, 0, 32'h00000000, 0, 0};
    tbl[2]  = '{0, 0, 4'h0, 32'h0,         1, 3,  0, 3,   0, 0,  4'h0, 1, 32'h11223344, 0, 32'h00000000, 0, 0};
    tbl[3]  = '{1, 3, 4'h5, 32'hAABBCCDD,  0, 3,  1, 3,   0, 0,  4'h0, 0, 32'h11223344, 1, 32'h11BB33DD, 0, 0};
    tbl[4]  = '{0, 0, 4'h0, 32'h0,         1, 3,  0, 3,   0, 0,  4'h0, 1, 32'h11BB33DD, 0, 32'h11BB33DD, 0, 0};
    tbl[5]  = '{0, 0, 4'h0, 32'h0,         1, 14, 1, 12,  0, 0,  4'hA, 1, 32'hC0804000, 1, 32'h0A0A0A0A, 0, 0};
    tbl[6]  = '{0, 0, 4'h0, 32'h0,         1, 13, 1, 15,  0, 0,  4'h0, 1, 32'h5A5A5A5A, 1, 32'h3C3C3C3C, 0, 0};
    tbl[7]  = '{1, 0, 4'hF, 32'hFFFFFFFF,  1, 0,  0, 15,  0, 0,  4'h0, 1, 32'h00000000, 0, 32'h3C3C3C3C, 0, 0};
    tbl[8]  = '{1, 14,4'hF, 32'hFFFFFFFF,  0, 0,  1, 14,  0, 0,  4'h0, 0, 32'h00000000, 1, 32'hC0804000, 0, 0};
    tbl[9]  = '{0, 0, 4'h0, 32'h0,         1, 0,  1, 14,  0, 0,  4'h0, 1, 32'h00000000, 1, 32'hC0804000, 0, 0};
    tbl[10] = '{0, 0, 4'h0, 32'h0,         1, 3,  1, 3,   0, 0,  4'h0, 1, 32'h11BB33DD, 1, 32'h11BB33DD, 0, 0};
    tbl[11] = '{0, 0, 4'h0, 32'h0,         0, 7,  0, 3,   1, 7,  4'h0, 0, 32'h11BB33DD, 0, 32'h11BB33DD, 1, 0};
    tbl[12] = '{1, 7, 4'hF, 32'h77777777,  0, 7,  0, 5,   1, 7,  4'h0, 0, 32'h11BB33DD, 0, 32'h11BB33DD, 1, 0};
    tbl[13] = '{1, 7, 4'h1, 32'h00000099,  1, 7,  0, 5,   0, 0,  4'h0, 1, 32'h77777799, 0, 32'h11BB33DD, 0, 0};
    tbl[14] = '{0, 0, 4'h0, 32'h0,         0, 0,  0, 0,   1, 0,  4'h0, 0, 32'h77777799, 0, 32'h11BB33DD, 0, 0};
    tbl[15] = '{0, 0, 4'h0, 32'h0,         0, 13, 0, 13,  1, 13, 4'h0, 0, 32'h77777799, 0, 32'h11BB33DD, 0, 0};
    tbl[16] = '{0, 0, 4'h0, 32'h0,         1, 7,  0, 7,   1, 7,  4'h0, 1, 32'h77777799, 0, 32'h11BB33DD, 1, 1};

    idle();
    bus.i_y = 8'h5A;
    bus.i_time = 8'h3C;

    // Reset edge
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_init_done", 32'(bus.init_done), 32'd0);
    check("rst_r_valid1", 32'(bus.r_valid1), 32'd0);
    check("rst_r_valid2", 32'(bus.r_valid2), 32'd0);
    check("rst_r_data1", bus.r_data1, 32'h0);
    check("rst_r_data2", bus.r_data2, 32'h0);
    rst = 1'b0;

    // Clear phase with traffic that must be ignored
    bus.we = 1; bus.w_addr = 5; bus.w_lane_mask = 4'hF; bus.w_data = 32'hFFFFFFFF;
    bus.issue_valid = 1; bus.issue_addr = 5;
    bus.re1 = 1; bus.r_addr1 = 5;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      check($sformatf("init_done_c%0d", i), 32'(bus.init_done), (i == 11) ? 32'd1 : 32'd0);
      if (i < 11) check($sformatf("init_rv1_c%0d", i), 32'(bus.r_valid1), 32'd0);
    end
    idle();

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      check($sformatf("v%0d_r_valid1", i), 32'(bus.r_valid1), 32'(tbl[i].ev1));
      check($sformatf("v%0d_r_data1", i), bus.r_data1, tbl[i].ed1);
      check($sformatf("v%0d_r_valid2", i), 32'(bus.r_valid2), 32'(tbl[i].ev2));
      check($sformatf("v%0d_r_data2", i), bus.r_data2, tbl[i].ed2);
      check($sformatf("v%0d_busy1", i), 32'(bus.busy1), 32'(tbl[i].eb1));
      check($sformatf("v%0d_busy2", i), 32'(bus.busy2), 32'(tbl[i].eb2));
    end
    idle();

    // Issue is not forwarded to busy in the same cycle
    bus.issue_valid = 1; bus.issue_addr = 9; bus.r_addr1 = 9;
    #1;
    check("issue_same_cycle_busy1", 32'(bus.busy1), 32'd0);
    @(posedge clk); #1;
    check("issue_next_cycle_busy1", 32'(bus.busy1), 32'd1);
    idle();

    // Reset in the middle of RUN with v7 busy and a read pending
    rst = 1'b1; bus.re1 = 1; bus.r_addr1 = 7;
    @(posedge clk); #1;
    check("midrst_r_valid1", 32'(bus.r_valid1), 32'd0);
    check("midrst_busy1", 32'(bus.busy1), 32'd0);
    check("midrst_init_done", 32'(bus.init_done), 32'd0);
    rst = 1'b0;
    idle();
    wait_init("midrst_init_cycles");

    // Storage was cleared again
    bus.re1 = 1; bus.r_addr1 = 7; bus.re2 = 1; bus.r_addr2 = 3;
    @(posedge clk); #1;
    check("post_clear_v7", bus.r_data1, 32'h0);
    check("post_clear_v3", bus.r_data2, 32'h0);
    check("post_clear_busy1", 32'(bus.busy1), 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
